// File: rtl/spi_config_master_if.sv
// -----------------------------------------------------------------------------
// spi_config_master_if
//
// Bundles the host-side byte stream and the four SPI wires of the SNN chip
// configuration port.
//
//   start       host -> master   one-cycle frame request
//   byte_count  host -> master   number of bytes in the frame (sampled with start)
//   tx_data     host -> master   next byte to send
//   tx_valid    host -> master   tx_data valid
//   tx_ready    master -> host   byte accepted this cycle
//   rx_data     master -> host   last full byte sampled from MISO
//   rx_valid    master -> host   one-cycle pulse, rx_data updated
//   busy        master -> host   frame in progress
//   done        master -> host   one-cycle pulse at frame end
//   SCLK        master -> target serial clock, idle low
//   MOSI        master -> target serial data out
//   SS          master -> target active-low select, idle high
//   MISO        target -> master serial data in
//
// modport master : the view of spi_config_master
// modport slave  : the view of the host / target side
// -----------------------------------------------------------------------------
interface spi_config_master_if #(
    parameter int CNT_W = 9
);
    logic             start;
    logic [CNT_W-1:0] byte_count;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             busy;
    logic             done;
    logic             SCLK;
    logic             MOSI;
    logic             SS;
    logic             MISO;

    modport master (
        input  start, byte_count, tx_data, tx_valid, MISO,
        output tx_ready, rx_data, rx_valid, busy, done, SCLK, MOSI, SS
    );

    modport slave (
        output start, byte_count, tx_data, tx_valid, MISO,
        input  tx_ready, rx_data, rx_valid, busy, done, SCLK, MOSI, SS
    );
endinterface

// File: rtl/spi_config_master.sv
// -----------------------------------------------------------------------------
// spi_config_master
//
// SPI mode-0 initiator for the SNN chip configuration port. A host byte stream
// (valid/ready) is serialised MSB-first on MOSI inside one SS-low frame while
// the byte returned on MISO is captured in parallel. After the last byte,
// TRAIL_CLKS extra SCLK pulses with MOSI=0 are issued so the target's
// SCLK-clocked two-stage MOSI synchroniser can flush the final bits.
//
// Parameters
//   CLK_DIV    : SCLK half-period in system_clock cycles (>= 1)
//   TRAIL_CLKS : flush SCLK pulses after the last byte (0..7)
//   CNT_W      : width of byte_count (must match the interface)
//
// Ports
//   system_clock : sole clock, rising edge
//   reset        : asynchronous, active-low
//   bus          : spi_config_master_if.master (host stream + SPI wires)
// -----------------------------------------------------------------------------
module spi_config_master #(
    parameter int CLK_DIV    = 4,
    parameter int TRAIL_CLKS = 2,
    parameter int CNT_W      = 9
) (
    input  logic                        system_clock,
    input  logic                        reset,
    spi_config_master_if.master         bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_TRAIL = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]       state_reg,    state_next;
    logic [DIV_W-1:0] div_reg,      div_next;
    logic [2:0]       bit_reg,      bit_next;
    logic [2:0]       trail_reg,    trail_next;
    logic [CNT_W-1:0] cnt_reg,      cnt_next;
    // Only the seven bits still to be sent after the MSB are kept; the MSB
    // goes straight to MOSI at the handshake.
    logic [6:0]       tx_shift_reg, tx_shift_next;
    // The seven most recent MISO bits; the eighth completes rx_byte.
    logic [6:0]       rx_shift_reg, rx_shift_next;
    logic [7:0]       rx_data_reg,  rx_data_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             done_reg,     done_next;
    logic             busy_reg,     busy_next;
    logic             ss_reg,       ss_next;
    logic             sclk_reg,     sclk_next;
    logic             mosi_reg,     mosi_next;

    logic             div_last;
    logic [7:0]       rx_byte;

    assign div_last = (div_reg == DIV_W'(CLK_DIV - 1));
    assign rx_byte  = {rx_shift_reg, bus.MISO};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        div_next      = div_reg;
        bit_next      = bit_reg;
        trail_next    = trail_reg;
        cnt_next      = cnt_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        rx_data_next  = rx_data_reg;
        rx_valid_next = 1'b0;
        done_next     = 1'b0;
        busy_next     = busy_reg;
        ss_next       = ss_reg;
        sclk_next     = sclk_reg;
        mosi_next     = mosi_reg;

        case (state_reg)
            ST_IDLE: begin
                div_next = '0;
                if (bus.start) begin
                    if (bus.byte_count != '0) begin
                        cnt_next   = bus.byte_count;
                        ss_next    = 1'b0;
                        busy_next  = 1'b1;
                        state_next = ST_LEAD;
                    end else begin
                        // Empty frame: acknowledge without touching the bus.
                        done_next = 1'b1;
                    end
                end
            end

            ST_LEAD: begin
                if (div_last) begin
                    div_next   = '0;
                    state_next = ST_LOAD;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end

            ST_LOAD: begin
                // tx_ready is high for the whole state, so tx_valid alone
                // completes the handshake. SCLK stays low while stalled.
                if (bus.tx_valid) begin
                    tx_shift_next = bus.tx_data[6:0];
                    mosi_next     = bus.tx_data[7];
                    bit_next      = '0;
                    div_next      = '0;
                    state_next    = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (!div_last) begin
                    div_next = div_reg + DIV_W'(1);
                end else begin
                    div_next = '0;
                    if (!sclk_reg) begin
                        // Rising edge: capture MISO.
                        sclk_next     = 1'b1;
                        rx_shift_next = rx_byte[6:0];
                        if (bit_reg == 3'd7) begin
                            rx_data_next  = rx_byte;
                            rx_valid_next = 1'b1;
                        end
                    end else begin
                        // Falling edge: advance MOSI or close the byte.
                        sclk_next = 1'b0;
                        if (bit_reg != 3'd7) begin
                            bit_next      = bit_reg + 3'd1;
                            mosi_next     = tx_shift_reg[6];
                            tx_shift_next = {tx_shift_reg[5:0], 1'b0};
                        end else begin
                            bit_next = '0;
                            cnt_next = cnt_reg - CNT_W'(1);
                            if (cnt_reg != CNT_W'(1)) begin
                                state_next = ST_LOAD;
                            end else begin
                                mosi_next = 1'b0;
                                if (TRAIL_CLKS == 0) begin
                                    ss_next    = 1'b1;
                                    state_next = ST_GAP;
                                end else begin
                                    trail_next = '0;
                                    state_next = ST_TRAIL;
                                end
                            end
                        end
                    end
                end
            end

            ST_TRAIL: begin
                if (!div_last) begin
                    div_next = div_reg + DIV_W'(1);
                end else begin
                    div_next = '0;
                    if (!sclk_reg) begin
                        sclk_next = 1'b1;
                    end else begin
                        sclk_next = 1'b0;
                        if (trail_reg == 3'(TRAIL_CLKS - 1)) begin
                            trail_next = '0;
                            ss_next    = 1'b1;
                            state_next = ST_GAP;
                        end else begin
                            trail_next = trail_reg + 3'd1;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (div_last) begin
                    div_next   = '0;
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end else begin
                    div_next = div_reg + DIV_W'(1);
                end
            end

            default: begin
                state_next = ST_IDLE;
                div_next   = '0;
                busy_next  = 1'b0;
                ss_next    = 1'b1;
                sclk_next  = 1'b0;
                mosi_next  = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset drops SS and SCLK to idle at once and discards any
    // partially shifted byte; no done pulse follows an aborted frame.
    // ------------------------------------------------------------------
    always_ff @(posedge system_clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            div_reg      <= '0;
            bit_reg      <= '0;
            trail_reg    <= '0;
            cnt_reg      <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            rx_data_reg  <= '0;
            rx_valid_reg <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            ss_reg       <= 1'b1;
            sclk_reg     <= 1'b0;
            mosi_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_reg      <= div_next;
            bit_reg      <= bit_next;
            trail_reg    <= trail_next;
            cnt_reg      <= cnt_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            rx_data_reg  <= rx_data_next;
            rx_valid_reg <= rx_valid_next;
            done_reg     <= done_next;
            busy_reg     <= busy_next;
            ss_reg       <= ss_next;
            sclk_reg     <= sclk_next;
            mosi_reg     <= mosi_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tx_ready = (state_reg == ST_LOAD);
    assign bus.rx_data  = rx_data_reg;
    assign bus.rx_valid = rx_valid_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.SCLK     = sclk_reg;
    assign bus.MOSI     = mosi_reg;
    assign bus.SS       = ss_reg;

endmodule

// File: tb/tb_spi_config_master.sv
// -----------------------------------------------------------------------------
// tb_spi_config_master
//
// Directed bench for spi_config_master with CLK_DIV=2, TRAIL_CLKS=2. A mode-0
// target model decodes MOSI and returns bytes from miso_table on MISO; a
// host driver feeds tx_table through the valid/ready stream.
// -----------------------------------------------------------------------------
module tb_spi_config_master;

    localparam int CLK_DIV    = 2;
    localparam int TRAIL_CLKS = 2;
    localparam int CNT_W      = 9;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    spi_config_master_if #(.CNT_W(CNT_W)) bus ();

    spi_config_master #(
        .CLK_DIV    (CLK_DIV),
        .TRAIL_CLKS (TRAIL_CLKS),
        .CNT_W      (CNT_W)
    ) dut (
        .system_clock (clk),
        .reset        (rst_n),
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    logic [7:0] tx_table   [0:511];
    logic [7:0] miso_table [0:511];
    logic [7:0] decoded    [0:511];
    logic [7:0] rx_log     [0:1023];

    // Free-running monitor totals; frames are measured as differences.
    int ss_low_total = 0, done_total = 0, busy_total = 0, ready_total = 0;
    int stall_err_total = 0, rx_total = 0, ss_falls_total = 0;
    // Per-frame target state, restarted on each SS fall.
    int rises = 0, sbit = 0, byte_idx = 0;
    logic [7:0] mosi_sh = 8'h00;
    logic [7:0] cur     = 8'h00;
    logic ss_prev = 1'b1, sclk_prev = 1'b0;

    // Monitor and mode-0 target, evaluated on the falling system clock edge.
    always @(negedge clk) begin
        if (!bus.SS)                  ss_low_total++;
        if (bus.done)                 done_total++;
        if (bus.busy)                 busy_total++;
        if (bus.tx_ready)             ready_total++;
        if (bus.tx_ready && bus.SCLK) stall_err_total++;
        if (bus.rx_valid) begin
            rx_log[rx_total[9:0]] = bus.rx_data;
            rx_total++;
        end
        if (ss_prev && !bus.SS) begin
            ss_falls_total++;
            rises    = 0;
            sbit     = 0;
            byte_idx = 0;
            cur      = miso_table[0];
            bus.MISO = cur[7];
        end else if (!bus.SS) begin
            if (!sclk_prev && bus.SCLK) begin
                mosi_sh = {mosi_sh[6:0], bus.MOSI};
                rises++;
                sbit++;
                if (sbit == 8) begin
                    decoded[byte_idx] = mosi_sh;
                    byte_idx++;
                    sbit = 0;
                end
            end else if (sclk_prev && !bus.SCLK) begin
                if (sbit == 0) cur = miso_table[byte_idx];
                bus.MISO = cur[7 - sbit];
            end
        end
        ss_prev   = bus.SS;
        sclk_prev = bus.SCLK;
    end

    int b_ss, b_done, b_busy, b_ready, b_stall, b_rx, b_falls;

    task automatic snap();
        b_ss = ss_low_total; b_done = done_total; b_busy = busy_total;
        b_ready = ready_total; b_stall = stall_err_total; b_rx = rx_total;
        b_falls = ss_falls_total;
    endtask

    // Runs one frame of n bytes. toggle gates tx_valid pseudo-randomly,
    // abort_rise asserts reset once that many SCLK rises have been seen,
    // repulse_rise issues a stray start (byte_count=5) mid-frame.
    task automatic run_frame(input int n, input bit toggle, input int abort_rise,
                             input int repulse_rise, output int hs,
                             output bit finished, output int cyc);
        bit repulsed;
        hs = 0; finished = 0; repulsed = 0; cyc = 0;
        @(negedge clk); #1;
        bus.start = 1'b1;
        bus.byte_count = 9'(n);
        @(negedge clk); #1;
        bus.start = 1'b0;
        while (!finished && cyc < 30000) begin
            if (bus.done) begin
                finished = 1;
            end else if (abort_rise != 0 && rises >= abort_rise) begin
                bus.tx_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                check_val("abort_ss",   32'(bus.SS),   32'h1);
                check_val("abort_sclk", 32'(bus.SCLK), 32'h0);
                check_val("abort_busy", 32'(bus.busy), 32'h0);
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
                $display("frame n=%0d aborted at rise %0d handshakes=%0d", n, rises, hs);
                return;
            end else begin
                if (repulse_rise != 0 && !repulsed && rises >= repulse_rise) begin
                    bus.start = 1'b1;
                    bus.byte_count = 9'd5;
                    repulsed = 1;
                end else begin
                    bus.start = 1'b0;
                end
                bus.tx_valid = (hs < n) && (toggle ? ($urandom_range(0, 2) != 0) : 1'b1);
                bus.tx_data  = tx_table[hs];
                if (bus.tx_valid && bus.tx_ready) hs++;
                @(negedge clk); #1;
                cyc++;
            end
        end
        bus.tx_valid = 1'b0;
        bus.start    = 1'b0;
        check_val("frame_done_seen", 32'(finished), 32'h1);
        $display("frame n=%0d handshakes=%0d rises=%0d cycles=%0d", n, hs, rises, cyc);
        repeat (4) @(negedge clk);
    endtask

    int  hs, cyc;
    bit  fin;

    initial begin
        rst_n = 1'b1;
        bus.start = 1'b0; bus.byte_count = '0; bus.tx_data = '0; bus.tx_valid = 1'b0;
        for (int i = 0; i < 512; i++) begin
            tx_table[i] = 8'h00; miso_table[i] = 8'h00; decoded[i] = 8'h00;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk); #1;
        check_val("rst_ss",       32'(bus.SS),       32'h1);
        check_val("rst_sclk",     32'(bus.SCLK),     32'h0);
        check_val("rst_mosi",     32'(bus.MOSI),     32'h0);
        check_val("rst_tx_ready", 32'(bus.tx_ready), 32'h0);
        check_val("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        check_val("rst_done",     32'(bus.done),     32'h0);
        check_val("rst_busy",     32'(bus.busy),     32'h0);
        check_val("rst_rx_data",  32'(bus.rx_data),  32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: 10 rises, SS low 2+1+40 cycles, busy adds GAP.
        tx_table[0] = 8'hA5; miso_table[0] = 8'h5A;
        snap();
        run_frame(1, 0, 0, 0, hs, fin, cyc);
        check_val("t1_hs",      32'(hs), 32'd1);
        check_val("t1_decoded", 32'(decoded[0]), 32'hA5);
        check_val("t1_rises",   32'(rises), 32'd10);
        check_val("t1_ss_low",  32'(ss_low_total - b_ss), 32'd43);
        check_val("t1_busy",    32'(busy_total - b_busy), 32'd45);
        check_val("t1_done",    32'(done_total - b_done), 32'd1);
        check_val("t1_rx_cnt",  32'(rx_total - b_rx), 32'd1);
        check_val("t1_rx_data", 32'(rx_log[b_rx]), 32'h5A);

        // Full duplex: send 0x81 while the target returns 0x3C.
        tx_table[0] = 8'h81; miso_table[0] = 8'h3C;
        snap();
        run_frame(1, 0, 0, 0, hs, fin, cyc);
        check_val("t2_decoded", 32'(decoded[0]), 32'h81);
        check_val("t2_rx_cnt",  32'(rx_total - b_rx), 32'd1);
        check_val("t2_rx_data", 32'(rx_log[b_rx]), 32'h3C);
        check_val("t2_rx_hold", 32'(bus.rx_data), 32'h3C);

        // 272-byte image with a stalling host.
        for (int i = 0; i < 272; i++) begin
            tx_table[i]   = 8'(i * 37 + 11);
            miso_table[i] = 8'(i * 13) ^ 8'h96;
        end
        snap();
        run_frame(272, 1, 0, 0, hs, fin, cyc);
        check_val("t3_hs",       32'(hs), 32'd272);
        check_val("t3_rx_cnt",   32'(rx_total - b_rx), 32'd272);
        check_val("t3_rises",    32'(rises), 32'd2178);
        check_val("t3_stall",    32'(stall_err_total - b_stall), 32'd0);
        check_val("t3_ss_falls", 32'(ss_falls_total - b_falls), 32'd1);
        check_val("t3_done",     32'(done_total - b_done), 32'd1);
        for (int i = 0; i < 272; i++) begin
            check_val($sformatf("t3_mosi_%0d", i), 32'(decoded[i]), 32'(tx_table[i]));
            check_val($sformatf("t3_miso_%0d", i), 32'(rx_log[b_rx + i]), 32'(miso_table[i]));
        end

        // Empty frame.
        snap();
        run_frame(0, 0, 0, 0, hs, fin, cyc);
        check_val("t4_latency",  32'(cyc), 32'd0);
        check_val("t4_done",     32'(done_total - b_done), 32'd1);
        check_val("t4_ss_low",   32'(ss_low_total - b_ss), 32'd0);
        check_val("t4_busy",     32'(busy_total - b_busy), 32'd0);
        check_val("t4_ready",    32'(ready_total - b_ready), 32'd0);

        // Reset on the 4th rise of byte 2 (rise 12), then a clean frame.
        for (int i = 0; i < 3; i++) begin
            tx_table[i] = 8'(8'h40 + i); miso_table[i] = 8'(8'hC0 + i);
        end
        snap();
        run_frame(3, 0, 12, 0, hs, fin, cyc);
        repeat (10) @(negedge clk); #1;
        check_val("t5_no_done", 32'(done_total - b_done), 32'd0);
        check_val("t5_rx_clr",  32'(bus.rx_data), 32'h00);
        check_val("t5_ss_idle", 32'(bus.SS), 32'h1);
        tx_table[0] = 8'hC3; tx_table[1] = 8'h1E;
        miso_table[0] = 8'h77; miso_table[1] = 8'hE8;
        snap();
        run_frame(2, 0, 0, 0, hs, fin, cyc);
        check_val("t5_dec0",   32'(decoded[0]), 32'hC3);
        check_val("t5_dec1",   32'(decoded[1]), 32'h1E);
        check_val("t5_rx0",    32'(rx_log[b_rx]), 32'h77);
        check_val("t5_rx1",    32'(rx_log[b_rx + 1]), 32'hE8);
        check_val("t5_rises",  32'(rises), 32'd18);
        check_val("t5_ss_low", 32'(ss_low_total - b_ss), 32'd76);
        check_val("t5_done",   32'(done_total - b_done), 32'd1);

        // Stray start with byte_count=5 during SHIFT must not alter the frame.
        snap();
        run_frame(2, 0, 0, 3, hs, fin, cyc);
        check_val("t6_hs",       32'(hs), 32'd2);
        check_val("t6_rises",    32'(rises), 32'd18);
        check_val("t6_rx_cnt",   32'(rx_total - b_rx), 32'd2);
        check_val("t6_ss_low",   32'(ss_low_total - b_ss), 32'd76);
        check_val("t6_ss_falls", 32'(ss_falls_total - b_falls), 32'd1);
        check_val("t6_done",     32'(done_total - b_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
